// File: rtl/rsc_frame_encoder.sv
// Rate-1/2 recursive systematic convolutional encoder (feedback 1+D+D^2, feedforward 1+D^2)
// with two-step trellis termination and BPSK soft-symbol mapping on a registered output stage.
module rsc_frame_encoder #(
  parameter int N_BITS = 16,
  parameter int W      = 12,
  parameter int AMP    = 256
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_bit,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_sys,
  output logic [W-1:0] out_par,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sof,
  output logic         out_eof,
  output logic         out_tail
);

  localparam int CW = (N_BITS > 2) ? $clog2(N_BITS) : 1;
  localparam logic [W-1:0] SYM_ZERO = W'(AMP);
  localparam logic [W-1:0] SYM_ONE  = W'(-AMP);

  typedef enum logic [1:0] {DATA, TAIL0, TAIL1} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          s1, s2;
  logic          advance, step, u, a, p;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= DATA;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (step) begin
      unique case (state)
        DATA: begin
          if (cnt == CW'(N_BITS - 1)) begin
            cnt_nx   = '0;
            state_nx = TAIL0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        TAIL0:   state_nx = TAIL1;
        TAIL1:   state_nx = DATA;
        default: state_nx = DATA;
      endcase
    end
  end

  // Output / control logic; in_ready depends only on registers, out_ready and reset
  always_comb begin
    advance  = !out_valid || out_ready;
    in_ready = advance && (state == DATA) && !reset;
    step     = advance && ((state != DATA) || in_valid);
    // Tail input equals the feedback sum, so a is forced to 0 and the trellis drains to (0,0)
    u        = (state == DATA) ? in_bit : (s1 ^ s2);
    a        = u ^ s1 ^ s2;
    p        = a ^ s2;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      out_valid <= 1'b0;
      out_sys   <= '0;
      out_par   <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_tail  <= 1'b0;
    end else if (step) begin
      s1        <= a;
      s2        <= s1;
      out_valid <= 1'b1;
      out_sys   <= u ? SYM_ONE : SYM_ZERO;
      out_par   <= p ? SYM_ONE : SYM_ZERO;
      out_sof   <= (state == DATA) && (cnt == '0);
      out_tail  <= (state != DATA);
      out_eof   <= (state == TAIL1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rsc_frame_encoder.sv
// Self-checking bench for rsc_frame_encoder: fixed-vector table, corner-case sequences,
// and a randomized handshake run scored against a frame-level reference model.
module tb_rsc_frame_encoder;

  localparam int N   = 4;
  localparam int W   = 12;
  localparam int AMP = 256;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_bit = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_sof, out_eof, out_tail;
  logic [W-1:0] out_sys, out_par;

  int total = 0;
  int bad   = 0;
  int frames_done = 0;

  always #5 clock = ~clock;

  rsc_frame_encoder #(.N_BITS(N), .W(W), .AMP(AMP)) dut (
    .clock(clock), .reset(reset),
    .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .out_sys(out_sys), .out_par(out_par), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .out_tail(out_tail)
  );

  typedef struct {
    logic [W-1:0] sys, par;
    logic sof, tail, eof;
  } pair_t;

  typedef struct {
    logic vld, bit_in;
    logic [W-1:0] sys, par;
    logic sof, tail, eof, rdy;
  } vec_t;

  vec_t  tbl [6];
  pair_t exp_q[$];
  logic  frame_bits[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] sym(input logic b);
    return b ? W'(-AMP) : W'(AMP);
  endfunction

  // Reference: recompute the whole frame prefix from the register-free recursion
  // a[j] = u[j]^a[j-1]^a[j-2], p[j] = a[j]^a[j-2]; tail steps pick u so a[j]=0.
  function automatic void push_expected(input int k);
    logic a [0:N+1];
    logic am1, am2, u, p;
    pair_t e;
    u = 1'b0;
    p = 1'b0;
    for (int j = 0; j <= k; j++) begin
      am1 = (j >= 1) ? a[j-1] : 1'b0;
      am2 = (j >= 2) ? a[j-2] : 1'b0;
      if (j < N) begin
        u    = frame_bits[j];
        a[j] = u ^ am1 ^ am2;
      end else begin
        u    = am1 ^ am2;
        a[j] = 1'b0;
      end
      p = a[j] ^ am2;
    end
    e.sys  = sym(u);
    e.par  = sym(p);
    e.sof  = (k == 0);
    e.tail = (k >= N);
    e.eof  = (k == N + 1);
    exp_q.push_back(e);
  endfunction

  // Scoreboard / protocol monitor, sampled on the falling edge
  bit          prev_stall = 1'b0;
  logic [26:0] prev_word;
  always @(negedge clock) begin
    pair_t e;
    if (reset) begin
      exp_q.delete();
      frame_bits.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({out_sys, out_par, out_sof, out_tail, out_eof}), 32'(prev_word));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra_pair: got sys=%0h par=%0h expected no pair", out_sys, out_par);
        end else begin
          e = exp_q.pop_front();
          check("sb_sys", 32'(out_sys), 32'(e.sys));
          check("sb_par", 32'(out_par), 32'(e.par));
          check("sb_flags", 32'({out_sof, out_tail, out_eof}), 32'({e.sof, e.tail, e.eof}));
        end
        if (out_eof) begin
          frames_done++;
          check("end_state", 32'({dut.s1, dut.s2}), 32'd0);
        end
      end
      if (in_valid && in_ready) begin
        frame_bits.push_back(in_bit);
        push_expected(frame_bits.size() - 1);
        if (frame_bits.size() == N) begin
          push_expected(N);
          push_expected(N + 1);
          frame_bits.delete();
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_sys, out_par, out_sof, out_tail, out_eof};
    end
  end

  task automatic check_row(input string tag, input int i);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sys"},   32'(out_sys),   32'(tbl[i].sys));
    check({tag, "_par"},   32'(out_par),   32'(tbl[i].par));
    check({tag, "_flags"}, 32'({out_sof, out_tail, out_eof}),
          32'({tbl[i].sof, tbl[i].tail, tbl[i].eof}));
    check({tag, "_rdy"},   32'(in_ready),  32'(tbl[i].rdy));
  endtask

  task automatic run_table(input string tag, input int stall);
    for (int i = 0; i < 6; i++) begin
      in_valid  = tbl[i].vld;
      in_bit    = tbl[i].bit_in;
      out_ready = 1'b1;
      @(posedge clock); #1;
      check_row(tag, i);
      if (i == 0 && stall > 0) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bit    = tbl[1].bit_in;
        for (int s = 0; s < stall; s++) begin
          @(posedge clock); #1;
          check({tag, "_stall_rdy"}, 32'(in_ready), 32'd0);
          check({tag, "_stall_sys"}, 32'(out_sys), 32'(tbl[0].sys));
        end
      end
    end
    in_valid = 1'b0;
    @(posedge clock); #1;
    check({tag, "_idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    int start;
    tbl[0] = '{1'b1, 1'b1, 12'hF00, 12'hF00, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 12'h100, 12'hF00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 12'hF00, 12'h100, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 12'hF00, 12'h100, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 12'h100, 12'hF00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 12'hF00, 12'hF00, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_sys",   32'(out_sys), 32'd0);
    check("rst_par",   32'(out_par), 32'd0);
    check("rst_flags", 32'({out_sof, out_eof, out_tail}), 32'd0);
    reset = 1'b0;

    // Basic frame 1,0,1,1
    run_table("basic", 0);

    // All-zero frame
    for (int i = 0; i < 6; i++) begin
      in_valid  = (i < N);
      in_bit    = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      check("zero_valid", 32'(out_valid), 32'd1);
      check("zero_sym", 32'({out_sys, out_par}), 32'({12'h100, 12'h100}));
    end
    in_valid = 1'b0;
    @(posedge clock); #1;

    // Backpressure for 3 cycles after the first pair
    run_table("stall", 3);

    // Back-to-back frames with no bubble
    for (int c = 0; c < 12; c++) begin
      in_valid  = 1'b1;
      in_bit    = tbl[c % 6].bit_in;
      out_ready = 1'b1;
      @(posedge clock); #1;
      check_row("b2b", c % 6);
    end
    in_valid = 1'b0;
    @(posedge clock); #1;
    check("b2b_idle", 32'(out_valid), 32'd0);

    // Asynchronous reset after two data bits
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_bit   = tbl[i].bit_in;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    @(posedge clock); #1;
    run_table("after_rst", 0);

    // Randomized handshakes, 200 frames against the scoreboard
    start = frames_done;
    cyc   = 0;
    while ((frames_done - start) < 200 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bit    = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
      cyc++;
    end
    check("random_frames", 32'(frames_done - start), 32'd200);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsc_frame_encoder.md
Name: rsc_frame_encoder

Overview:
- Rate-1/2 recursive systematic convolutional (RSC) encoder. It is the transmit-side counterpart of the MAP decoder.
- Accepts a frame of information bits over a valid/ready handshake and appends trellis-termination tail bits so every frame ends in state 0.
- Maps each systematic and parity bit to a 12-bit two's-complement BPSK soft value, the same format the decoder consumes on its systematic and parity inputs.
- Sits between the frame source and the channel model / decoder input memories in the test and loopback path.

Parameters:
- N_BITS, 16, information bits per frame (≥2).
- W, 12, soft-symbol width in bits.
- AMP, 256, magnitude of the mapped symbol. Bit 0 maps to +AMP, bit 1 maps to −AMP. AMP must be below 2^(W−1).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_bit  in  1  information bit.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  encoder accepts in_bit this cycle.
- out_sys  out  W  mapped systematic symbol.
- out_par  out  W  mapped parity symbol.
- out_valid  out  1  output symbol pair is valid.
- out_ready  in  1  downstream consumes the pair this cycle.
- out_sof  out  1  pair belongs to the first information bit of the frame.
- out_eof  out  1  pair is the last tail bit of the frame.
- out_tail  out  1  pair belongs to a tail (termination) step.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_sys=0, out_par=0, out_sof=0, out_eof=0, out_tail=0.
- Reset clears the trellis state (s1,s2)=(0,0), the bit counter, and sets FSM=DATA. Reset mid-frame discards the partial frame; the next accepted bit starts a new frame.
- Trellis step, generators feedback 1+D+D², feedforward 1+D²:
  - a = u ^ s1 ^ s2
  - p = a ^ s2
  - next (s1,s2) = (a, s1)
  - Systematic bit = u.
- Output stage is a single register.
  - advance = !out_valid | out_ready.
  - A step happens when advance is high and, in DATA, in_valid is also high.
  - out_valid sets on a step and clears when out_ready is high with no step in that cycle.
  - Latency: 1 cycle from accepted bit to out_valid.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
- in_ready = advance & (FSM==DATA). Output is a combinational function of registers and out_ready only; no in_valid→in_ready path.
- FSM DATA:
  - Each accepted bit encodes with u=in_bit and increments cnt.
  - out_sof=1 when cnt==0.
  - When cnt reaches N_BITS−1 on an accept, cnt resets to 0 and FSM moves to TAIL.
- FSM TAIL:
  - Two steps, no input consumed. Steps occur on advance regardless of in_valid.
  - u = s1 ^ s2, which forces a=0; p = s2.
  - out_tail=1 on both steps; out_eof=1 on the second step.
  - After the second step, FSM returns to DATA with (s1,s2)=(0,0), guaranteed by construction.
- Symbol mapping: bit 0 gives +AMP, bit 1 gives −AMP, sign-extended to W bits. AMP=256, W=12 gives 0x100 / 0xF00.
- Back-to-back frames: the first bit of the next frame may be accepted in the cycle after the second tail step's advance. There are no idle bubbles when out_ready is held high.
- Throughput: one pair per cycle with out_ready held high. A frame takes N_BITS+2 output cycles.

Test Plan:
- N_BITS=4; reset; bits 1,0,1,1 with out_ready=1 → sys 1,0,1,1,0,1 and par 1,1,0,0,1,1. Mapped: out_sys 0xF00,0x100,0xF00,0xF00,0x100,0xF00. Flags: sof on pair 0, tail on pairs 4–5, eof on pair 5. in_ready=0 during the 2 tail cycles.
- N_BITS=4, all-zero input → all 6 pairs 0x100/0x100. Trellis state stays (0,0).
- Backpressure: hold out_ready=0 for 3 cycles after the first pair → in_ready=0, outputs frozen. Release → stream resumes with no loss or duplication; sequence identical to the first test.
- Back-to-back frames 1,0,1,1 then 1,0,1,1 with in_valid and out_ready held high → 12 consecutive valid pairs with no bubble. The second frame's output is identical to the first, which shows the trellis terminated.
- Assert reset after 2 data bits → out_valid=0 immediately (asynchronous). Then bits 1,0,1,1 → output matches the first test exactly.
- Randomized in_valid/out_ready over 200 frames vs a reference model → every pair matches, and every frame ends with (s1,s2)=(0,0) after eof.
